// File: rtl/decoder_scan_if.sv
// Request/response bundle for decoder_scan: binary select request in, one-hot strobe out.
// The master drives requests and abort; the slave (the decoder) returns the decoded pattern and status.
interface decoder_scan_if #(
    parameter int IN_W    = 2,
    parameter int DWELL_W = 4
);
    localparam int OUT_W = 2 ** IN_W;

    logic [IN_W-1:0]    in;
    logic               en;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               in_valid;
    logic               in_ready;
    logic               abort;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic               busy;
    logic               done;

    modport master (
        output in, en, mode, dwell, in_valid, abort,
        input  in_ready, out, out_valid, busy, done
    );

    modport slave (
        input  in, en, mode, dwell, in_valid, abort,
        output in_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/decoder_scan.sv
// Binary-to-one-hot decoder with a registered output.
// Direct mode decodes one request; scan mode walks every line from a start index, holding each dwell+1 cycles.
module decoder_scan #(
    parameter int IN_W    = 2,
    parameter int DWELL_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    decoder_scan_if.slave bus
);
    localparam int OUT_W = 2 ** IN_W;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [IN_W-1:0]    idx, idx_nxt;
    logic [IN_W-1:0]    pcnt, pcnt_nxt;
    logic [DWELL_W-1:0] dcnt, dcnt_nxt;
    logic [DWELL_W-1:0] dwell_r, dwell_nxt;

    logic [OUT_W-1:0]   out_q, out_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;

    logic accept;
    logic hold_end;
    logic scan_end;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign hold_end     = (dcnt == dwell_r);
    // pcnt counts positions already finished, so all-ones means the final position is holding.
    assign scan_end     = hold_end && (&pcnt);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            pcnt        <= '0;
            dcnt        <= '0;
            dwell_r     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            pcnt        <= pcnt_nxt;
            dcnt        <= dcnt_nxt;
            dwell_r     <= dwell_nxt;
            out_q       <= out_nxt;
            out_valid_q <= out_valid_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // Next-state and scan counters.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        state_nxt = state;
        idx_nxt   = idx;
        pcnt_nxt  = pcnt;
        dcnt_nxt  = dcnt;
        dwell_nxt = dwell_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_nxt   = bus.in;
                    pcnt_nxt  = '0;
                    dcnt_nxt  = '0;
                    dwell_nxt = bus.dwell;
                    if (bus.mode && bus.en) state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (bus.abort || scan_end) begin
                    state_nxt = IDLE;
                end else if (hold_end) begin
                    dcnt_nxt = '0;
                    idx_nxt  = idx + 1'b1;
                    pcnt_nxt = pcnt + 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs: the pattern shown next cycle follows the index chosen above.
    always_comb begin
        out_nxt       = '0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    out_valid_nxt = 1'b1;
                    busy_nxt      = bus.mode && bus.en;
                    if (bus.en) out_nxt = OUT_W'(1) << bus.in;
                end
            end
            SCAN: begin
                if (bus.abort || scan_end) begin
                    done_nxt = 1'b1;
                end else begin
                    out_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    out_nxt       = OUT_W'(1) << idx_nxt;
                end
            end
            default: ;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised successor to the 2-to-4 enable decoder.
- Binary-to-one-hot decoder with a registered output and a valid/ready input handshake.
- Mode 0 (direct): decodes a single request.
- Mode 1 (scan): auto-sequences through every output line from a start index, holding each for a programmable dwell time.
- Used as the channel-select and strobe generator ahead of muxed peripherals.

Parameters:
- IN_W, 2, width of the binary select input. OUT_W = 2**IN_W, derived internally, not overridable.
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in  input  IN_W  binary index: direct-mode target, or scan start index
- en  input  1  enable, sampled on accept. 0 forces an all-zero output pattern.
- mode  input  1  sampled on accept. 0 = direct, 1 = scan.
- dwell  input  DWELL_W  sampled on accept. Each scan position is held dwell+1 cycles.
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- abort  input  1  terminates an active scan
- out  output  OUT_W  registered one-hot (or zero) output
- out_valid  output  1  out carries a decoded pattern this cycle
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when a scan completes or is aborted

Behaviour:
- Accept occurs on a rising edge where in_valid && in_ready. in, en, mode and dwell are captured into internal registers at accept.
- in_ready is 1 in IDLE and 0 in SCAN. It is also held 0 while rst is high (combinational).
- Reset (rst high at an edge):
  - state=IDLE; out=0, out_valid=0, busy=0, done=0
  - index and dwell counters cleared
  - reset mid-scan abandons the scan with no done pulse
- States: IDLE, SCAN.
- IDLE, accept with mode=0 (direct):
  - next cycle: out = en ? (1 << in) : 0, out_valid=1
  - state stays IDLE; latency 1 cycle
  - back-to-back accepts every cycle give one output per cycle
  - no accept → out=0, out_valid=0
- IDLE, accept with mode=1 and en=0:
  - treated as direct; next cycle out=0, out_valid=1, no scan
- IDLE, accept with mode=1 and en=1:
  - state→SCAN, busy=1 from the next cycle
  - idx := in; dcnt := 0; next cycle out = 1 << in, out_valid=1
- SCAN, every cycle:
  - if dcnt == dwell_r: dcnt := 0 and idx advances by 1 modulo OUT_W (wraps OUT_W-1→0). Otherwise dcnt increments.
  - out = 1 << idx, out_valid=1
- Scan completion:
  - after OUT_W positions have each been held dwell_r+1 cycles, i.e. OUT_W*(dwell_r+1) out_valid cycles in total
  - next edge: out=0, out_valid=0, busy=0, done=1 for exactly one cycle, state→IDLE
  - in_ready=1 in that same cycle, so a request presented in the done cycle is accepted
- Abort:
  - abort=1 at an edge in SCAN: next cycle out=0, out_valid=0, busy=0, done=1, state→IDLE
  - abort in IDLE is ignored
  - abort in the same cycle as the natural last-hold cycle produces a single done pulse
- Invariants:
  - out never has more than one bit set
  - out_valid=0 implies out=0
  - dwell=0 gives one cycle per position
  - dwell=2**DWELL_W-1 must not overflow dcnt, so dcnt is DWELL_W bits and compares with equality
- in, en, mode and dwell changing during SCAN have no effect.

Test Plan:
- Reset, then direct mode with en=1 sweeping in=0..3 on consecutive cycles → out=0001, 0010, 0100, 1000 one cycle after each accept, out_valid=1 each cycle, in_ready stays 1.
- Direct mode with en=0, in=2 → out=0000, out_valid=1 for one cycle. Next idle cycle → out_valid=0.
- Scan with in=2, dwell=1 → out=0100,0100,1000,1000,0001,0001,0010,0010 (8 cycles), then out=0000, done=1 for 1 cycle; busy=1 and in_ready=0 throughout the scan.
- Scan with in=0, dwell=0; new request (mode=0, in=3) held valid from the start; abort=1 on the 2nd scan cycle → request not accepted during scan; out 0001,0010 then 0000 with done=1; the request is accepted in the done cycle → out=1000 on the following cycle.
- Scan with in=1, dwell=3; rst=1 asserted on cycle 5 → next cycle out=0000, out_valid=0, busy=0, done=0; in_ready=0 while rst is high, 1 after release.
- IN_W=3, DWELL_W=2, scan with in=7, dwell=3 → wraps 7→0 after 4 cycles; 32 out_valid cycles total, last pattern 0x40, then done pulse.
